// File: rtl/csidh_result_tx.sv
// Serialises the CSIDH core result A_out into word_size-bit words, least-significant word first, with valid/ready handshaking.
// Optional macro CSIDH_RESULT_RANGE_CHECK_EN also flags A_out >= p as invalid in the frame status.
module csidh_result_tx #(
   parameter int N = 512,
   parameter int word_size = 32,
   parameter logic [N-1:0] p = 512'h65B48E8F740F89BFFC8AB0D15E3E4C4AB42D083AEDC88C425AFBFCC69322C9CDA7AAC6C567F35507516730CC1F0B4F25C2721BF457ACA8351B81B90533C6C87B
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 done,
   input  logic [N-1:0]         A_out,
   input  logic                 invalid,
   output logic [word_size-1:0] out_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 out_last,
   output logic                 out_invalid,
   output logic                 busy,
   output logic                 overrun
);

   localparam int WORDS = N / word_size;
   localparam int CW    = (WORDS > 1) ? $clog2(WORDS) : 1;

   // An even or non-divisible configuration is a setup error, caught at elaboration.
   if ((N % word_size) != 0) begin : gBadRatio
      $error("csidh_result_tx: N must be a multiple of word_size");
   end
   if (p[0] == 1'b0) begin : gBadModulus
      $error("csidh_result_tx: modulus p must be odd");
   end

   typedef enum logic {IDLE, SEND} state_t;

   state_t         state_q;
   logic [N-1:0]   shiftReg_q;
   logic [CW-1:0]  count_q;
   logic           doneDelay_q;
   logic           status_q;
   logic           last_q;
   logic           overrun_q;
   logic           status_d;
   logic           capture;

   assign capture = done & ~doneDelay_q;

`ifdef CSIDH_RESULT_RANGE_CHECK_EN
   assign status_d = invalid | (A_out >= p);
`else
   assign status_d = invalid;
`endif

   // The shift register drains to zero as words leave, so its low word doubles as the idle-zero output.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         shiftReg_q  <= '0;
         count_q     <= '0;
         doneDelay_q <= 1'b0;
         status_q    <= 1'b0;
         last_q      <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         doneDelay_q <= done;
         case (state_q)
            IDLE: begin
               if (capture) begin
                  shiftReg_q <= A_out;
                  status_q   <= status_d;
                  count_q    <= '0;
                  last_q     <= (WORDS == 1);
                  state_q    <= SEND;
               end
            end
            SEND: begin
               if (capture) begin
                  overrun_q <= 1'b1;
               end
               if (out_ready) begin
                  shiftReg_q <= shiftReg_q >> word_size;
                  count_q    <= count_q + CW'(1);
                  if (last_q) begin
                     state_q  <= IDLE;
                     last_q   <= 1'b0;
                     status_q <= 1'b0;
                  end else begin
                     last_q <= (int'(count_q) + 2 == WORDS);
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign out_valid   = (state_q == SEND);
   assign busy        = (state_q == SEND);
   assign out_data    = shiftReg_q[word_size-1:0];
   assign out_last    = last_q;
   assign out_invalid = status_q;
   assign overrun     = overrun_q;

endmodule

// File: tb/tb_csidh_result_tx.sv
// Self-checking bench for csidh_result_tx: scoreboard of expected words, directed frames, stalls, overrun and reset abort.
module tb_csidh_result_tx;

   localparam logic [511:0] P_PRIME = 512'h65B48E8F740F89BFFC8AB0D15E3E4C4AB42D083AEDC88C425AFBFCC69322C9CDA7AAC6C567F35507516730CC1F0B4F25C2721BF457ACA8351B81B90533C6C87B;

`ifdef CSIDH_RESULT_RANGE_CHECK_EN
   localparam logic RANGE_ON = 1'b1;
`else
   localparam logic RANGE_ON = 1'b0;
`endif

   typedef struct packed {
      logic [31:0] data;
      logic        last;
      logic        inv;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst;
   logic         done;
   logic [511:0] A_out;
   logic         invalid;
   logic [31:0]  out_data;
   logic         out_valid;
   logic         out_ready;
   logic         out_last;
   logic         out_invalid;
   logic         busy;
   logic         overrun;

   exp_t sbQ[$];
   int   nAsserts = 0;
   int   nFails   = 0;

   csidh_result_tx dut (
      .clk(clk), .rst(rst), .done(done), .A_out(A_out), .invalid(invalid),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_last(out_last), .out_invalid(out_invalid), .busy(busy), .overrun(overrun)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nAsserts++;
      assert (obs === exp) else begin
         nFails++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Monitor: pops the scoreboard on every handshake and checks stalled words stay put.
   logic [31:0] prevData = '0;
   logic        prevLast = 1'b0;
   logic        prevInv  = 1'b0;
   logic        prevStall = 1'b0;
   always @(negedge clk) begin
      exp_t e;
      if (out_valid && prevStall) begin
         checkOutput("hold_data", 64'(out_data), 64'(prevData));
         checkOutput("hold_last", 64'(out_last), 64'(prevLast));
         checkOutput("hold_inv", 64'(out_invalid), 64'(prevInv));
      end
      if (out_valid && out_ready) begin
         if (sbQ.size() == 0) begin
            checkOutput("extra_word_valid", 64'(out_valid), 64'(0));
         end else begin
            e = sbQ.pop_front();
            checkOutput("word_data", 64'(out_data), 64'(e.data));
            checkOutput("word_last", 64'(out_last), 64'(e.last));
            checkOutput("word_inv", 64'(out_invalid), 64'(e.inv));
         end
      end
      prevStall = out_valid && !out_ready;
      prevData  = out_data;
      prevLast  = out_last;
      prevInv   = out_invalid;
   end

   function automatic logic readyFor(input int mode, input int c);
      return (mode == 0) ? 1'b1 : ((c % 3) == 0);
   endfunction

   task automatic pushFrame(input logic [511:0] a, input logic expInv);
      exp_t e;
      for (int i = 0; i < 16; i++) begin
         e.data = a[32*i +: 32];
         e.last = (i == 15);
         e.inv  = expInv;
         sbQ.push_back(e);
      end
   endtask

   task automatic checkIdle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         checkOutput("idle_valid", 64'(out_valid), 64'(0));
         checkOutput("idle_busy", 64'(busy), 64'(0));
         checkOutput("idle_data", 64'(out_data), 64'(0));
         checkOutput("idle_last", 64'(out_last), 64'(0));
      end
   endtask

   // Entered one step after the capture edge; runs the frame out, with optional overrun pulse or reset.
   task automatic drainFrame(input int mode, input int overrunAt, input int rstAt,
                             input logic holdDone, output int cycles);
      int c = 0;
      out_ready = readyFor(mode, 0);
      while (c < 200) begin
         @(posedge clk); #1;
         c++;
         if (c == rstAt) begin
            rst = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
            checkOutput("rst_abort_valid", 64'(out_valid), 64'(0));
            checkOutput("rst_abort_busy", 64'(busy), 64'(0));
            checkOutput("rst_abort_overrun", 64'(overrun), 64'(0));
            checkOutput("rst_abort_data", 64'(out_data), 64'(0));
            sbQ.delete();
            break;
         end
         if (!out_valid) break;
         out_ready = readyFor(mode, c);
         if (c == overrunAt) begin
            done  = 1'b1;
            A_out = '1;
         end else if (!holdDone) begin
            done = 1'b0;
         end
      end
      if (!holdDone) done = 1'b0;
      cycles = c;
   endtask

   task automatic applyStimulus(input logic [511:0] a, input logic inv, input logic expInv,
                                input int mode, input int overrunAt, input int rstAt,
                                input logic holdDone);
      int cycles;
      @(posedge clk); #1;
      A_out   = a;
      invalid = inv;
      done    = 1'b1;
      pushFrame(a, expInv);
      @(negedge clk);
      checkOutput("pre_capture_valid", 64'(out_valid), 64'(0));
      @(posedge clk); #1;
      done    = holdDone;
      A_out   = ~a;
      invalid = ~inv;
      checkOutput("first_valid_latency", 64'(out_valid), 64'(1));
      checkOutput("first_busy", 64'(busy), 64'(1));
      drainFrame(mode, overrunAt, rstAt, holdDone, cycles);
      if (rstAt < 0) begin
         checkOutput("frame_cycles", 64'(cycles), (mode == 0) ? 64'(16) : 64'(46));
         checkOutput("words_remaining", 64'(sbQ.size()), 64'(0));
      end
   endtask

   initial begin
      logic [511:0] frameA;
      int cycles;
      for (int i = 0; i < 16; i++) frameA[32*i +: 32] = 32'(i + 1);

      rst = 1'b1; done = 1'b0; A_out = '0; invalid = 1'b0; out_ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkOutput("reset_valid", 64'(out_valid), 64'(0));
      checkOutput("reset_busy", 64'(busy), 64'(0));
      checkOutput("reset_overrun", 64'(overrun), 64'(0));
      checkOutput("reset_data", 64'(out_data), 64'(0));
      checkOutput("reset_last", 64'(out_last), 64'(0));
      checkOutput("reset_inv", 64'(out_invalid), 64'(0));
      @(posedge clk); #1;
      rst = 1'b0;

      $display("[TB] frame with constant ready");
      applyStimulus(frameA, 1'b0, 1'b0, 0, -1, -1, 1'b0);
      checkIdle(2);

      $display("[TB] frame with ready pattern 1,0,0");
      applyStimulus(frameA, 1'b0, 1'b0, 1, -1, -1, 1'b0);
      checkIdle(2);

      $display("[TB] rejected key frame");
      applyStimulus('0, 1'b1, 1'b1, 0, -1, -1, 1'b0);
      checkIdle(2);

      $display("[TB] done held high");
      applyStimulus(frameA, 1'b0, 1'b0, 0, -1, -1, 1'b1);
      checkIdle(4);
      checkOutput("held_done_overrun", 64'(overrun), 64'(0));
      done = 1'b0;
      checkIdle(1);

      $display("[TB] second done rise mid-frame");
      applyStimulus(frameA, 1'b0, 1'b0, 0, 5, -1, 1'b0);
      checkOutput("overrun_set", 64'(overrun), 64'(1));
      checkIdle(4);
      checkOutput("overrun_sticky", 64'(overrun), 64'(1));

      $display("[TB] reset at word 8");
      applyStimulus(frameA, 1'b0, 1'b0, 0, -1, 8, 1'b0);
      checkIdle(4);

      $display("[TB] done rise on final transfer");
      applyStimulus(frameA, 1'b0, 1'b0, 0, 15, -1, 1'b0);
      checkOutput("final_overrun", 64'(overrun), 64'(1));
      checkIdle(4);
      @(posedge clk); #1; rst = 1'b1;
      @(posedge clk); #1; rst = 1'b0;

      $display("[TB] range check on p and p-1");
      applyStimulus(P_PRIME, 1'b0, RANGE_ON, 0, -1, -1, 1'b0);
      checkIdle(1);
      applyStimulus(P_PRIME - 512'd1, 1'b0, 1'b0, 0, -1, -1, 1'b0);
      checkIdle(1);

      $display("[TB] done high across reset release");
      @(posedge clk); #1;
      rst = 1'b1; done = 1'b1; A_out = frameA; invalid = 1'b0;
      pushFrame(frameA, 1'b0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      checkOutput("rst_release_idle", 64'(out_valid), 64'(0));
      @(posedge clk); #1;
      checkOutput("post_reset_capture", 64'(out_valid), 64'(1));
      A_out = '0;
      drainFrame(0, -1, -1, 1'b0, cycles);
      checkOutput("post_reset_cycles", 64'(cycles), 64'(16));
      checkOutput("post_reset_remaining", 64'(sbQ.size()), 64'(0));
      checkIdle(2);

      $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
      $finish;
   end

endmodule
